// File: rtl/rect_swap_ctrl.sv
// Swap-attempt sequencer: each attempt picks a 2x2 rectangle from an LFSR and
// inverts it when it is a checkerboard, so every row and column sum is preserved.
module rect_swap_ctrl #(
   parameter int unsigned ROW_LEN   = 4,
   parameter int unsigned COL_LEN   = 4,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_2345
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [31:0]                instr,
   input  logic                       start,
   input  logic                       load_en,
   input  logic [ROW_LEN*COL_LEN-1:0] load_data,
   output logic [ROW_LEN*COL_LEN-1:0] matrix_out,
   output logic                       busy,
   output logic                       done,
   output logic [11:0]                swaps_done
);

   localparam int unsigned RW = $clog2(ROW_LEN);
   localparam int unsigned CW = $clog2(COL_LEN);
   localparam int unsigned MW = ROW_LEN * COL_LEN;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {S_IDLE, S_PICK, S_CHECK, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [MW-1:0]   matrix_q, matrix_d;
   logic [31:0]     lfsr_q, lfsr_d, lfsr_next;
   logic [11:0]     remaining_q, remaining_d;
   logic [11:0]     swaps_q, swaps_d;
   logic [RW-1:0]   r1_q, r1_d, r2_q, r2_d;
   logic [CW-1:0]   c1_q, c1_d, c2_q, c2_d;

   logic [RW+CW-1:0] i11, i12, i21, i22;
   logic             b11, b12, b21, b22, valid;
   logic             unused_instr;

   assign unused_instr = ^instr[31:12];

   // Power-of-two dimensions make r*COL_LEN+c a plain concatenation.
   assign i11 = {r1_q, c1_q};
   assign i12 = {r1_q, c2_q};
   assign i21 = {r2_q, c1_q};
   assign i22 = {r2_q, c2_q};
   assign b11 = matrix_q[i11];
   assign b12 = matrix_q[i12];
   assign b21 = matrix_q[i21];
   assign b22 = matrix_q[i22];
   assign valid = (r1_q != r2_q) && (c1_q != c2_q) &&
                  (b11 == b22) && (b12 == b21) && (b11 != b12);

   assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : '0);

   always_comb begin
      state_d     = state_q;
      matrix_d    = matrix_q;
      lfsr_d      = lfsr_q;
      remaining_d = remaining_q;
      swaps_d     = swaps_q;
      r1_d        = r1_q;
      r2_d        = r2_q;
      c1_d        = c1_q;
      c2_d        = c2_q;
      case (state_q)
         S_IDLE: begin
            if (load_en) begin
               matrix_d = load_data;
            end else if (start) begin
               remaining_d = instr[11:0];
               swaps_d     = '0;
               state_d     = (instr[11:0] != 12'd0) ? S_PICK : S_DONE;
            end
         end
         S_PICK: begin
            lfsr_d  = lfsr_next;
            r1_d    = lfsr_next[RW-1:0];
            c1_d    = lfsr_next[8 +: CW];
            r2_d    = lfsr_next[16 +: RW];
            c2_d    = lfsr_next[24 +: CW];
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (valid) begin
               matrix_d[i11] = ~b11;
               matrix_d[i12] = ~b12;
               matrix_d[i21] = ~b21;
               matrix_d[i22] = ~b22;
               if (swaps_q != 12'hFFF) swaps_d = swaps_q + 12'd1;
            end
            remaining_d = remaining_q - 12'd1;
            state_d     = (remaining_q == 12'd1) ? S_DONE : S_PICK;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         matrix_q    <= '0;
         lfsr_q      <= LFSR_SEED;
         remaining_q <= '0;
         swaps_q     <= '0;
         r1_q        <= '0;
         r2_q        <= '0;
         c1_q        <= '0;
         c2_q        <= '0;
      end else begin
         state_q     <= state_d;
         matrix_q    <= matrix_d;
         lfsr_q      <= lfsr_d;
         remaining_q <= remaining_d;
         swaps_q     <= swaps_d;
         r1_q        <= r1_d;
         r2_q        <= r2_d;
         c1_q        <= c1_d;
         c2_q        <= c2_d;
      end
   end

   assign matrix_out = matrix_q;
   assign busy       = (state_q == S_PICK) || (state_q == S_CHECK);
   assign done       = (state_q == S_DONE);
   assign swaps_done = swaps_q;

endmodule

// File: tb/tb_rect_swap_ctrl.sv
// Bench for rect_swap_ctrl: idle-behaviour vector table plus attempt-by-attempt
// comparison against a 4x4 matrix model driven by its own copy of the LFSR rule.
module tb_rect_swap_ctrl;

   localparam logic [31:0] SEED = 32'hACE1_2345;
   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] instr = '0;
   logic        start = 1'b0;
   logic        load_en = 1'b0;
   logic [15:0] load_data = '0;
   logic [15:0] matrix_out;
   logic        busy, done;
   logic [11:0] swaps_done;

   rect_swap_ctrl #(.ROW_LEN(4), .COL_LEN(4), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .start(start),
      .load_en(load_en), .load_data(load_data), .matrix_out(matrix_out),
      .busy(busy), .done(done), .swaps_done(swaps_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] m_mat;
   logic [31:0] m_lfsr;
   int          m_swaps;

   typedef struct {
      bit          load_en;
      bit          start;
      logic [15:0] data;
      logic [31:0] instr;
      logic [15:0] exp_mat;
      bit          exp_busy;
      bit          exp_done;
   } vec_t;

   vec_t vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic int bitat(input logic [15:0] m, input int r, input int c);
      return int'(m[r*4 + c]);
   endfunction

   // One attempt of the reference: advance LFSR, pick corners, flip a checkerboard.
   task automatic model_attempt();
      int r1, c1, r2, c2, a, b, c, d;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? TAPS : 32'h0);
      r1 = int'(m_lfsr & 32'h3);
      c1 = int'((m_lfsr >> 8) & 32'h3);
      r2 = int'((m_lfsr >> 16) & 32'h3);
      c2 = int'((m_lfsr >> 24) & 32'h3);
      a = bitat(m_mat, r1, c1); b = bitat(m_mat, r1, c2);
      c = bitat(m_mat, r2, c1); d = bitat(m_mat, r2, c2);
      if (r1 != r2 && c1 != c2 && a == d && b == c && a != b) begin
         m_mat[r1*4 + c1] = ~m_mat[r1*4 + c1];
         m_mat[r1*4 + c2] = ~m_mat[r1*4 + c2];
         m_mat[r2*4 + c1] = ~m_mat[r2*4 + c1];
         m_mat[r2*4 + c2] = ~m_mat[r2*4 + c2];
         if (m_swaps < 4095) m_swaps++;
      end
   endtask

   task automatic model_reset();
      m_mat = '0; m_lfsr = SEED; m_swaps = 0;
   endtask

   task automatic load(input logic [15:0] d);
      @(negedge clk);
      load_en = 1'b1; load_data = d;
      @(negedge clk);
      load_en = 1'b0;
      m_mat = d;
      chk("load", matrix_out, d);
   endtask

   task automatic check_pops();
      for (int r = 0; r < 4; r++) begin
         int cnt = 0;
         for (int c = 0; c < 4; c++) cnt += int'(matrix_out[r*4 + c]);
         chk("row_pop", cnt, 1);
      end
      for (int c = 0; c < 4; c++) begin
         int cnt = 0;
         for (int r = 0; r < 4; r++) cnt += int'(matrix_out[r*4 + c]);
         chk("col_pop", cnt, 1);
      end
   endtask

   // Starts a run of n attempts and checks every attempt as it lands.
   task automatic run(input int n, input int disturb_at, input int reset_at, input bit pops);
      @(negedge clk);
      instr = 32'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_swaps = 0;
      if (n == 0) begin
         chk("n0_done", done, 1); chk("n0_busy", busy, 0);
         chk("n0_mat", matrix_out, m_mat); chk("n0_swaps", swaps_done, 0);
         @(negedge clk);
         chk("n0_done_clear", done, 0);
         return;
      end
      for (int k = 1; k <= n; k++) begin
         chk("pick_busy", busy, 1);
         if (k == disturb_at) begin
            start = 1'b1; load_en = 1'b1; load_data = 16'hFFFF; instr = 32'd3;
         end
         @(negedge clk);
         start = 1'b0; load_en = 1'b0;
         if (k == reset_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("arst_mat", matrix_out, 0); chk("arst_busy", busy, 0);
            chk("arst_done", done, 0); chk("arst_swaps", swaps_done, 0);
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            return;
         end
         @(negedge clk);
         model_attempt();
         chk("attempt_mat", matrix_out, m_mat);
         chk("attempt_swaps", swaps_done, 32'(m_swaps));
         chk("attempt_done", done, (k == n) ? 1 : 0);
         if (pops) check_pops();
      end
      chk("end_busy", busy, 0);
      @(negedge clk);
      chk("idle_done", done, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected run to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{1'b1, 1'b0, 16'hA5A5, 32'd0,          16'hA5A5, 1'b0, 1'b0};
      vt[1] = '{1'b1, 1'b1, 16'h3C3C, 32'd5,          16'h3C3C, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b0, 16'hFFFF, 32'd7,          16'h3C3C, 1'b0, 1'b0};
      vt[3] = '{1'b1, 1'b0, 16'hA5A5, 32'd0,          16'hA5A5, 1'b0, 1'b0};
      vt[4] = '{1'b0, 1'b1, 16'h0000, 32'hFFFF_F000,  16'hA5A5, 1'b0, 1'b1};
      vt[5] = '{1'b0, 1'b0, 16'h0000, 32'd0,          16'hA5A5, 1'b0, 1'b0};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mat", matrix_out, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0); chk("rst_swaps", swaps_done, 0);
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 6; i++) begin
         load_en = vt[i].load_en; start = vt[i].start;
         load_data = vt[i].data; instr = vt[i].instr;
         @(negedge clk);
         load_en = 1'b0; start = 1'b0;
         chk("vec_mat", matrix_out, vt[i].exp_mat);
         chk("vec_busy", busy, vt[i].exp_busy);
         chk("vec_done", done, vt[i].exp_done);
         chk("vec_swaps", swaps_done, 0);
      end
      m_mat = 16'hA5A5;

      run(0, 0, 0, 1'b0);

      load(16'h0000);
      run(100, 0, 0, 1'b0);
      chk("zero_swaps", swaps_done, 0);

      load(16'h8421);
      run(1000, 0, 0, 1'b1);

      load(16'($urandom));
      run(50, 20, 0, 1'b0);

      for (int i = 0; i < 4; i++) begin
         load(16'($urandom));
         run(int'($urandom_range(1, 40)), 0, 0, 1'b0);
      end

      load(16'h6996);
      run(500, 0, 123, 1'b0);
      load(16'h6996);
      run(500, 0, 0, 1'b0);
      chk("final_mat", matrix_out, m_mat);
      chk("final_swaps", swaps_done, 32'(m_swaps));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
